// File: rtl/hazard_stall_if.sv
// Pipeline-side view of the stall controller: D-stage operand usage, E/M
// destination timing, MDU issue, and the resulting enables and statistics.
interface hazard_stall_if #(
  parameter int REG_AW = 5,
  parameter int T_W    = 2,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] d_rs_addr;
  logic              d_rs_use;
  logic [T_W-1:0]    d_rs_tuse;
  logic [REG_AW-1:0] d_rt_addr;
  logic              d_rt_use;
  logic [T_W-1:0]    d_rt_tuse;
  logic              d_is_mdu;
  logic [REG_AW-1:0] e_wa;
  logic [T_W-1:0]    e_tnew;
  logic [REG_AW-1:0] m_wa;
  logic [T_W-1:0]    m_tnew;
  logic              e_mdu_start;
  logic              e_mdu_is_div;
  logic              pc_en;
  logic              d_en;
  logic              e_clr;
  logic              mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  mdu_stall_cnt;

  modport master (
    output d_rs_addr, d_rs_use, d_rs_tuse,
    output d_rt_addr, d_rt_use, d_rt_tuse,
    output d_is_mdu, e_wa, e_tnew, m_wa, m_tnew,
    output e_mdu_start, e_mdu_is_div,
    input  pc_en, d_en, e_clr, mdu_busy, stall_cnt, mdu_stall_cnt
  );

  modport slave (
    input  d_rs_addr, d_rs_use, d_rs_tuse,
    input  d_rt_addr, d_rt_use, d_rt_tuse,
    input  d_is_mdu, e_wa, e_tnew, m_wa, m_tnew,
    input  e_mdu_start, e_mdu_is_div,
    output pc_en, d_en, e_clr, mdu_busy, stall_cnt, mdu_stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Tuse/Tnew stall controller for the 5-stage pipeline with an internal
// multiply/divide busy timer and saturating stall statistics.
module hazard_stall_unit #(
  parameter int REG_AW   = 5,
  parameter int T_W      = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_stall_if.slave hz
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int TMR_W   = $clog2(MAX_LAT + 1);

  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  MULT_LOAD = TMR_W'(MULT_LAT);
  localparam logic [TMR_W-1:0]  DIV_LOAD  = TMR_W'(DIV_LAT);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};

  // A result is still in flight when the consumer needs it sooner than the producer delivers it.
  function automatic logic operand_hazard(
    input logic              src_use,
    input logic [REG_AW-1:0] src_addr,
    input logic [T_W-1:0]    src_tuse,
    input logic [REG_AW-1:0] dst_addr,
    input logic [T_W-1:0]    dst_tnew
  );
    return src_use & (src_addr == dst_addr) & (dst_addr != REG_ZERO) & (src_tuse < dst_tnew);
  endfunction

  logic             stall_data_s;
  logic             stall_mdu_s;
  logic             stall_s;
  logic [TMR_W-1:0] timer_d, timer_q;
  logic             mdu_busy_d, mdu_busy_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] mdu_stall_cnt_d, mdu_stall_cnt_q;

  // Hazard detection across both source operands and the E/M producers.
  always_comb begin
    stall_data_s = operand_hazard(hz.d_rs_use, hz.d_rs_addr, hz.d_rs_tuse, hz.e_wa, hz.e_tnew)
                 | operand_hazard(hz.d_rs_use, hz.d_rs_addr, hz.d_rs_tuse, hz.m_wa, hz.m_tnew)
                 | operand_hazard(hz.d_rt_use, hz.d_rt_addr, hz.d_rt_tuse, hz.e_wa, hz.e_tnew)
                 | operand_hazard(hz.d_rt_use, hz.d_rt_addr, hz.d_rt_tuse, hz.m_wa, hz.m_tnew);
    stall_mdu_s  = hz.d_is_mdu & (hz.e_mdu_start | mdu_busy_q);
    stall_s      = stall_data_s | stall_mdu_s;
  end

  // Pipeline enables; reset forces the free-running state regardless of hazards.
  always_comb begin
    hz.pc_en = 1'b1;
    hz.d_en  = 1'b1;
    hz.e_clr = 1'b0;
    if (reset) begin
      hz.pc_en = 1'b1;
      hz.d_en  = 1'b1;
      hz.e_clr = 1'b0;
    end else if (stall_s) begin
      hz.pc_en = 1'b0;
      hz.d_en  = 1'b0;
      hz.e_clr = 1'b1;
    end else begin
      hz.pc_en = 1'b1;
      hz.d_en  = 1'b1;
      hz.e_clr = 1'b0;
    end
  end

  // MDU timer: a new start always reloads, even over an operation still running.
  always_comb begin
    timer_d = timer_q;
    if (hz.e_mdu_start) begin
      if (hz.e_mdu_is_div) begin
        timer_d = DIV_LOAD;
      end else begin
        timer_d = MULT_LOAD;
      end
    end else if (timer_q != TMR_ZERO) begin
      timer_d = timer_q - TMR_ONE;
    end else begin
      timer_d = timer_q;
    end
    mdu_busy_d = (timer_d != TMR_ZERO);
  end

  // Saturating statistics; MDU-only stalls exclude cycles a data hazard would have stalled anyway.
  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    mdu_stall_cnt_d = mdu_stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (stall_mdu_s && !stall_data_s && (mdu_stall_cnt_q != CNT_MAX)) begin
      mdu_stall_cnt_d = mdu_stall_cnt_q + CNT_ONE;
    end else begin
      mdu_stall_cnt_d = mdu_stall_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q         <= TMR_ZERO;
      mdu_busy_q      <= 1'b0;
      stall_cnt_q     <= CNT_ZERO;
      mdu_stall_cnt_q <= CNT_ZERO;
    end else begin
      timer_q         <= timer_d;
      mdu_busy_q      <= mdu_busy_d;
      stall_cnt_q     <= stall_cnt_d;
      mdu_stall_cnt_q <= mdu_stall_cnt_d;
    end
  end

  assign hz.mdu_busy      = mdu_busy_q;
  assign hz.stall_cnt     = stall_cnt_q;
  assign hz.mdu_stall_cnt = mdu_stall_cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Parametrised stall controller for the 5-stage pipeline (F/D/E/M/W). It compares register use-times in D (Tuse) against result-ready times in E and M (Tnew) using one generalised rule. It owns the multiply/divide busy timer internally, with separate mult and div latencies. It drives PC/D-register enables and the E-register clear, and keeps saturating stall-statistics counters.

Parameters:
REG_AW, 5, register address width
T_W, 2, width of Tuse/Tnew fields
MULT_LAT, 5, cycles the MDU stays busy after a mult/multu start (>=1)
DIV_LAT, 10, cycles the MDU stays busy after a div/divu start (>=1)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
d_rs_addr  in  REG_AW  rs address of the D instruction
d_rs_use  in  1  D instruction reads rs
d_rs_tuse  in  T_W  cycles from D until rs is consumed
d_rt_addr  in  REG_AW  rt address of the D instruction
d_rt_use  in  1  D instruction reads rt
d_rt_tuse  in  T_W  cycles from D until rt is consumed
d_is_mdu  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
e_wa  in  REG_AW  destination register of the E instruction (0 = none)
e_tnew  in  T_W  cycles from E until the E result is forwardable
m_wa  in  REG_AW  destination register of the M instruction
m_tnew  in  T_W  cycles from M until the M result is forwardable
e_mdu_start  in  1  mult/div issuing in E this cycle
e_mdu_is_div  in  1  qualifies e_mdu_start: 1 = div latency, 0 = mult latency
pc_en  out  1  PC write enable
d_en  out  1  F/D register enable
e_clr  out  1  D/E register clear (inserts a bubble)
mdu_busy  out  1  internal MDU timer nonzero
stall_cnt  out  CNT_W  total stall cycles, saturating
mdu_stall_cnt  out  CNT_W  stall cycles caused only by the MDU, saturating

Behaviour:
- Data hazard per source operand X in {rs, rt}, per stage S in {E, M}:
  - haz_X_S = X_use & (X_addr == S_wa) & (S_wa != 0) & (X_tuse < S_tnew), unsigned compare.
  - stall_data is the OR of all four terms. W is never checked (Tnew is always 0 there).
- MDU hazard: stall_mdu = d_is_mdu & (e_mdu_start | mdu_busy).
- stall = stall_data | stall_mdu.
- Outputs are combinational:
  - stall: pc_en=0, d_en=0, e_clr=1.
  - otherwise: pc_en=1, d_en=1, e_clr=0.
  - while reset=1 the outputs are forced to 1/1/0.
- MDU timer (width clog2(max(MULT_LAT,DIV_LAT)+1)):
  - Reset clears it to 0.
  - On a clock edge with e_mdu_start=1 it loads DIV_LAT if e_mdu_is_div, else MULT_LAT. This reloads even if the timer is nonzero (restart wins).
  - Else, if nonzero, it decrements by 1.
  - mdu_busy = (timer != 0), registered.
  - A start in cycle t gives mdu_busy high for cycles t+1 .. t+LAT. An MDU instruction in D is held from cycle t through t+LAT and advances at t+LAT+1.
- e_mdu_start coincident with e_clr: the start is honoured. The clear affects only the next D/E contents.
- Counters (reset to 0):
  - stall_cnt increments on each clock where stall=1.
  - mdu_stall_cnt increments where stall_mdu=1 and stall_data=0.
  - Both hold at all-ones (saturate, no wrap).
- Reset mid-operation: timer, mdu_busy and counters clear immediately (asynchronous). The first edge after deassertion behaves as from cold.
- Reset values: pc_en=1, d_en=1, e_clr=0, mdu_busy=0, stall_cnt=0, mdu_stall_cnt=0.

Test Plan:
- Load-use: e_wa=8, e_tnew=2; D reads rs=8 with tuse=1. Required: one stall cycle, stall_cnt 0->1. Next cycle m_wa=8, m_tnew=1, tuse=1: no stall.
- Branch after ALU: e_wa=9, e_tnew=1; D reads rt=9 with tuse=0. Required: pc_en=0, d_en=0, e_clr=1. Repeat with e_wa=0: no stall.
- Mult then mflo: e_mdu_start=1, e_mdu_is_div=0 at cycle 0 with mflo in D. Required: stall cycles 0..5 (6 cycles), release at cycle 6, mdu_busy high cycles 1..5, mdu_stall_cnt=6.
- Div restart: div start at cycle 0, mult start at cycle 3. Required: mdu_busy high cycles 1..8, low at cycle 9.
- Simultaneous hazards: MDU busy plus rs hazard at the same time. Required: stall_cnt increments, mdu_stall_cnt does not.
- Reset and saturation: assert reset while timer=7. Required: mdu_busy=0 and counters=0 without a clock edge. With CNT_W=3, 10 stall cycles leave stall_cnt=7.
